// File: rtl/mem_burst_master.sv
// Strided load/store burst initiator for one data_memory port (1..16 words per Start).
// Latency: load 3 cycles/word (request, capture, hand-off), store 2 cycles/word (wait, write).
// Backpressure: RdReady low holds RdData/RdValid; WrValid low parks the burst in ST_WAIT.
module mem_burst_master #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 5
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Op,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [ADDR_W-1:0] Stride,
    input  logic [LEN_W-1:0]  Length,
    input  logic [DATA_W-1:0] WrData,
    input  logic              WrValid,
    output logic              WrReady,
    output logic [DATA_W-1:0] RdData,
    output logic              RdValid,
    input  logic              RdReady,
    output logic              Busy,
    output logic              Done,
    output logic [LEN_W-1:0]  Count,
    output logic [1:0]        Control,
    output logic [ADDR_W-1:0] DataAddr,
    output logic [DATA_W-1:0] DataIn,
    input  logic [DATA_W-1:0] DataOut
);

    typedef enum logic [2:0] {
        IDLE, LD_REQ, LD_CAP, LD_OUT, ST_WAIT, ST_REQ, DONE
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(16);

    state_t            state, nextState;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] strideReg;
    logic [LEN_W-1:0]  lenReg;
    logic [LEN_W-1:0]  lenClamped;
    logic [LEN_W-1:0]  cntNext;
    logic              lastWord;

    assign lenClamped = (Length > MAX_LEN) ? MAX_LEN : Length;
    assign cntNext    = Count + LEN_W'(1);
    assign lastWord   = (cntNext == lenReg);

    // DataAddr simply mirrors the burst address; memory ignores it unless Control is 2 or 3.
    assign DataAddr = addr;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            addr      <= '0;
            strideReg <= '0;
            lenReg    <= '0;
            Count     <= '0;
            RdData    <= '0;
            DataIn    <= '0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (Start) begin
                        addr      <= BaseAddr;
                        strideReg <= Stride;
                        lenReg    <= lenClamped;
                        Count     <= '0;
                    end
                end
                LD_CAP:  RdData <= DataOut;
                LD_OUT: begin
                    if (RdReady) begin
                        Count <= cntNext;
                        addr  <= addr + strideReg;
                    end
                end
                ST_WAIT: begin
                    if (WrValid) DataIn <= WrData;
                end
                ST_REQ: begin
                    Count <= cntNext;
                    addr  <= addr + strideReg;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nextState = state;
        Control   = 2'd0;
        RdValid   = 1'b0;
        WrReady   = 1'b0;
        Busy      = 1'b1;
        Done      = 1'b0;
        case (state)
            IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    if (Length == '0) nextState = DONE;
                    else if (Op)      nextState = ST_WAIT;
                    else              nextState = LD_REQ;
                end
            end
            LD_REQ: begin
                Control   = 2'd2;
                nextState = LD_CAP;
            end
            LD_CAP: nextState = LD_OUT;
            LD_OUT: begin
                RdValid = 1'b1;
                if (RdReady) nextState = lastWord ? DONE : LD_REQ;
            end
            ST_WAIT: begin
                WrReady = 1'b1;
                if (WrValid) nextState = ST_REQ;
            end
            ST_REQ: begin
                Control   = 2'd3;
                nextState = lastWord ? DONE : ST_WAIT;
            end
            DONE: begin
                Done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a behavioural data_memory (1-cycle read latency).
module tb_mem_burst_master;

    logic        Clock, Reset, Start, Op;
    logic [15:0] BaseAddr, Stride, WrData, RdData, DataAddr, DataIn, DataOut;
    logic [4:0]  Length, Count;
    logic        WrValid, WrReady, RdValid, RdReady, Busy, Done;
    logic [1:0]  Control;

    mem_burst_master #(.ADDR_W(16), .DATA_W(16), .LEN_W(5)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
        .BaseAddr(BaseAddr), .Stride(Stride), .Length(Length),
        .WrData(WrData), .WrValid(WrValid), .WrReady(WrReady),
        .RdData(RdData), .RdValid(RdValid), .RdReady(RdReady),
        .Busy(Busy), .Done(Done), .Count(Count), .Control(Control),
        .DataAddr(DataAddr), .DataIn(DataIn), .DataOut(DataOut)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // data_memory model: every word preloaded with its own address.
    logic [15:0] ram [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 16'(i);
        DataOut = '0;
        forever begin
            @(posedge Clock);
            if (Control == 2'd3) ram[DataAddr] = DataIn;
            if (Control == 2'd2) DataOut <= ram[DataAddr];
        end
    end

    // Bus activity log, sampled mid-cycle.
    int nRead = 0, nWrite = 0, nHs = 0;
    logic [15:0] addrLog [0:255];
    logic [15:0] rdLog   [0:255];
    initial begin
        forever begin
            @(negedge Clock);
            if (Control == 2'd2) begin
                if (nRead < 256) addrLog[nRead] = DataAddr;
                nRead++;
            end
            if (Control == 2'd3) nWrite++;
            if (RdValid && RdReady) begin
                if (nHs < 256) rdLog[nHs] = RdData;
                nHs++;
            end
        end
    end

    int nChecks = 0;
    int nFail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic waitDone(input int maxc, output int cyc);
        cyc = 0;
        while (Done !== 1'b1 && cyc < maxc) begin
            step();
            cyc++;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_control"}, 32'(Control),  0);
        check({tag, "_addr"},    32'(DataAddr), 0);
        check({tag, "_datain"},  32'(DataIn),   0);
        check({tag, "_rddata"},  32'(RdData),   0);
        check({tag, "_rdvalid"}, 32'(RdValid),  0);
        check({tag, "_wrready"}, 32'(WrReady),  0);
        check({tag, "_busy"},    32'(Busy),     0);
        check({tag, "_done"},    32'(Done),     0);
        check({tag, "_count"},   32'(Count),    0);
    endtask

    task automatic startCmd(input logic op, input logic [15:0] base, input logic [15:0] stride,
                            input logic [4:0] len);
        Op = op; BaseAddr = base; Stride = stride; Length = len; Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    initial begin
        int cyc, idx, r0, w0, h0;
        logic hs;
        Reset = 1'b1; Start = 1'b0; Op = 1'b0; BaseAddr = '0; Stride = '0; Length = '0;
        WrData = '0; WrValid = 1'b0; RdReady = 1'b0;
        step(); step();
        checkResetOutputs("reset");
        Reset = 1'b0;
        step();

        // Load burst 3,5,7 with RdReady held high.
        r0 = nRead; h0 = nHs; RdReady = 1'b1;
        startCmd(1'b0, 16'd3, 16'd2, 5'd3);
        check("ld_busy_at_start", 32'(Busy), 1);
        waitDone(40, cyc);
        check("ld_done_seen", 32'(Done), 1);
        check("ld_done_cycle", cyc, 9);
        check("ld_reads", nRead - r0, 3);
        check("ld_hs_count", nHs - h0, 3);
        check("ld_word0", 32'(rdLog[h0]), 3);
        check("ld_word1", 32'(rdLog[h0+1]), 5);
        check("ld_word2", 32'(rdLog[h0+2]), 7);
        check("ld_count", 32'(Count), 3);
        step();
        check("ld_idle_busy", 32'(Busy), 0);
        check("ld_count_hold", 32'(Count), 3);

        // Store burst A0..A3 to 12..15, streamed back-to-back.
        w0 = nWrite; WrData = 16'hA0; WrValid = 1'b1; idx = 0;
        startCmd(1'b1, 16'd12, 16'd1, 5'd4);
        cyc = 0;
        while (Done !== 1'b1 && cyc < 40) begin
            hs = WrReady && WrValid;
            step();
            cyc++;
            if (hs) begin
                idx++;
                WrData = 16'hA0 + 16'(idx);
            end
        end
        WrValid = 1'b0;
        check("st_done_seen", 32'(Done), 1);
        check("st_done_cycle", cyc, 8);
        check("st_writes", nWrite - w0, 4);
        check("st_ram12", 32'(ram[12]), 32'hA0);
        check("st_ram13", 32'(ram[13]), 32'hA1);
        check("st_ram14", 32'(ram[14]), 32'hA2);
        check("st_ram15", 32'(ram[15]), 32'hA3);
        check("st_count", 32'(Count), 4);
        step();

        // Backpressure: RdReady low for 5 cycles on word 0.
        r0 = nRead; h0 = nHs; RdReady = 1'b0;
        startCmd(1'b0, 16'd20, 16'd3, 5'd2);
        step(); step();
        for (int i = 0; i < 5; i++) begin
            check("bp_rdvalid_held", 32'(RdValid), 1);
            check("bp_rddata_held", 32'(RdData), 20);
            step();
        end
        check("bp_single_read", nRead - r0, 1);
        RdReady = 1'b1;
        waitDone(40, cyc);
        check("bp_done_seen", 32'(Done), 1);
        check("bp_word1", 32'(rdLog[h0+1]), 23);
        check("bp_count", 32'(Count), 2);
        step();

        // Wrap at 0xFFFF and clamp of Length 20 to 16.
        r0 = nRead; h0 = nHs;
        startCmd(1'b0, 16'hFFFF, 16'd1, 5'd20);
        waitDone(100, cyc);
        check("wr_done_seen", 32'(Done), 1);
        check("wr_reads", nRead - r0, 16);
        check("wr_addr0", 32'(addrLog[r0]), 32'hFFFF);
        check("wr_addr1", 32'(addrLog[r0+1]), 0);
        check("wr_addr15", 32'(addrLog[r0+15]), 32'hE);
        check("wr_data0", 32'(rdLog[h0]), 32'hFFFF);
        check("wr_data1", 32'(rdLog[h0+1]), 0);
        check("wr_count", 32'(Count), 16);
        step();

        // Length 0: straight to DONE, no memory traffic.
        r0 = nRead; w0 = nWrite;
        startCmd(1'b1, 16'd50, 16'd1, 5'd0);
        check("l0_done", 32'(Done), 1);
        check("l0_busy", 32'(Busy), 1);
        check("l0_count_cleared", 32'(Count), 0);
        step();
        check("l0_idle", 32'(Busy), 0);
        check("l0_no_access", (nRead - r0) + (nWrite - w0), 0);

        // Start while busy, including during DONE, is ignored.
        r0 = nRead; w0 = nWrite; h0 = nHs;
        startCmd(1'b0, 16'd40, 16'd1, 5'd2);
        step();
        Op = 1'b1; BaseAddr = 16'd100; Length = 5'd5; Start = 1'b1;
        step(); step();
        Start = 1'b0;
        waitDone(40, cyc);
        check("sb_done_seen", 32'(Done), 1);
        Op = 1'b0; Length = 5'd1; Start = 1'b1;
        step();
        Start = 1'b0;
        check("sb_done_start_ignored", 32'(Busy), 0);
        check("sb_reads", nRead - r0, 2);
        check("sb_no_writes", nWrite - w0, 0);
        check("sb_word0", 32'(rdLog[h0]), 40);
        check("sb_word1", 32'(rdLog[h0+1]), 41);
        check("sb_count", 32'(Count), 2);

        // Reset mid-store, during ST_WAIT of word 2.
        w0 = nWrite; WrData = 16'hB0; WrValid = 1'b1; idx = 0;
        startCmd(1'b1, 16'd200, 16'd2, 5'd4);
        cyc = 0;
        while (!((nWrite - w0) == 2 && WrReady) && cyc < 40) begin
            hs = WrReady && WrValid;
            step();
            cyc++;
            if (hs) begin
                idx++;
                WrData = 16'hB0 + 16'(idx);
            end
        end
        check("rs_reached_word2", 32'(WrReady), 1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        WrValid = 1'b0;
        checkResetOutputs("rs");
        check("rs_ram200", 32'(ram[200]), 32'hB0);
        check("rs_ram202", 32'(ram[202]), 32'hB1);
        check("rs_ram204", 32'(ram[204]), 204);
        check("rs_ram206", 32'(ram[206]), 206);
        step(); step();
        check("rs_no_more_writes", nWrite - w0, 2);

        // Start and Reset together: Reset wins.
        Reset = 1'b1; Start = 1'b1; Op = 1'b0; Length = 5'd3;
        step();
        Reset = 1'b0; Start = 1'b0;
        step();
        check("sr_busy", 32'(Busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
